// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with bubble/hold classification and statistics
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   stall            global stall vector (1 = stop); bit STAGE is upstream, bit STAGE+1 is downstream
//   flush            kill in-flight content, overrides any stall
//   in_valid/in_data upstream payload
//   out_valid/out_data registered payload to downstream
//   bubble_cnt, hold_cnt saturating statistics counters
//   stuck            sticky flag: hold persisted STUCK_LIMIT consecutive cycles
//   clr_stats        synchronous clear of counters and stuck
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned STAGE = 4,
  parameter bit CLR_ON_BUBBLE = 1'b1,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned STUCK_LIMIT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic               stuck,
  input  logic               clr_stats
);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STUCK_LIMIT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  if (STAGE >= STALL_W) begin : g_bad
    $error("pipe_stage_reg: STAGE must be below STALL_W");
  end
  logic up_stop, dn_stop, bubble, hold, unused_ok;
  assign up_stop = stall[STAGE];
  // The last stage has no consumer bit, so it can never be held from below.
  if (STAGE + 1 < STALL_W) begin : g_dn
    assign dn_stop = stall[STAGE+1];
  end else begin : g_top
    assign dn_stop = 1'b0;
  end
  assign unused_ok = ^stall;
  logic              valid_q, valid_d, stuck_q, stuck_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d, hcnt_q, hcnt_d, age_q, age_d;
  // Flush suppresses classification so counters never move on a flush cycle.
  assign bubble = ~flush & up_stop & ~dn_stop;
  assign hold = ~flush & up_stop & dn_stop;
  always_comb begin
    valid_d = (flush | bubble) ? 1'b0 : up_stop ? valid_q : in_valid;
    data_d = (flush | bubble) ? (CLR_ON_BUBBLE ? RST_VAL : data_q) : up_stop ? data_q : in_data;
    bcnt_d = clr_stats ? '0 : (bubble && bcnt_q != MAX) ? bcnt_q + ONE : bcnt_q;
    hcnt_d = clr_stats ? '0 : (hold && hcnt_q != MAX) ? hcnt_q + ONE : hcnt_q;
    age_d = (clr_stats || !hold) ? '0 : (age_q == LIM) ? age_q : age_q + ONE;
    stuck_d = ~clr_stats & (stuck_q | (hold & (age_d == LIM)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= RST_VAL;
      bcnt_q <= '0;
      hcnt_q <= '0;
      age_q <= '0;
      stuck_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      bcnt_q <= bcnt_d;
      hcnt_q <= hcnt_d;
      age_q <= age_d;
      stuck_q <= stuck_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign bubble_cnt = bcnt_q;
  assign hold_cnt = hcnt_q;
  assign stuck = stuck_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg in three configurations
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic rst, flush, in_valid, clr_stats;
  logic [63:0] in_data;
  logic [5:0] stall_a, stall_b, stall_c;
  logic va, vb, vc, sa, sb, sc;
  logic [63:0] da, db, dc;
  logic [15:0] ba, ha, bc, hc;
  logic [2:0] bb, hb;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;

  pipe_stage_reg u_a (
    .clk(clk), .rst(rst), .stall(stall_a), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(va), .out_data(da), .bubble_cnt(ba), .hold_cnt(ha), .stuck(sa), .clr_stats(clr_stats)
  );
  pipe_stage_reg #(.CLR_ON_BUBBLE(1'b0), .CNT_W(3), .STUCK_LIMIT(4)) u_b (
    .clk(clk), .rst(rst), .stall(stall_b), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(vb), .out_data(db), .bubble_cnt(bb), .hold_cnt(hb), .stuck(sb), .clr_stats(clr_stats)
  );
  pipe_stage_reg #(.STAGE(5)) u_c (
    .clk(clk), .rst(rst), .stall(stall_c), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(vc), .out_data(dc), .bubble_cnt(bc), .hold_cnt(hc), .stuck(sc), .clr_stats(clr_stats)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'hA5; clr_stats = 1'b0;
    stall_a = '0; stall_b = '0; stall_c = '0;
    tick();
    chk("rst_valid_0", 64'(va), 64'd0);
    chk("rst_data_0", da, 64'd0);
    tick();
    chk("rst_valid_1", 64'(va), 64'd0);
    chk("rst_data_1", da, 64'd0);
    chk("rst_bcnt", 64'(ba), 64'd0);
    chk("rst_hcnt", 64'(ha), 64'd0);
    chk("rst_stuck", 64'(sa), 64'd0);
    chk("rst_b_valid", 64'(vb), 64'd0);
    rst = 1'b0;
    tick();
    chk("adv_valid", 64'(va), 64'd1);
    chk("adv_data", da, 64'hA5);
    chk("adv_b_data", db, 64'hA5);
    stall_a = 6'b010000; stall_b = 6'b010000; in_data = 64'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bub_valid", 64'(va), 64'd0);
      chk("bub_data_clr", da, 64'd0);
      chk("bub_b_valid", 64'(vb), 64'd0);
      chk("bub_b_data_keep", db, 64'hA5);
    end
    chk("bub_bcnt", 64'(ba), 64'd3);
    chk("bub_hcnt", 64'(ha), 64'd0);
    chk("bub_b_bcnt", 64'(bb), 64'd3);
    stall_a = '0; stall_b = '0; in_data = 64'h22;
    tick();
    chk("lat22_valid", 64'(va), 64'd1);
    chk("lat22_data", da, 64'h22);
    stall_a = 6'b110000; in_data = 64'h33;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 64'(va), 64'd1);
      chk("hold_data", da, 64'h22);
    end
    chk("hold_hcnt", 64'(ha), 64'd5);
    chk("hold_bcnt", 64'(ba), 64'd3);
    chk("hold_stuck", 64'(sa), 64'd0);
    flush = 1'b1;
    tick();
    chk("flush_valid", 64'(va), 64'd0);
    chk("flush_data", da, 64'd0);
    chk("flush_hcnt", 64'(ha), 64'd5);
    chk("flush_bcnt", 64'(ba), 64'd3);
    chk("flush_b_valid", 64'(vb), 64'd0);
    chk("flush_b_data_keep", db, 64'h33);
    flush = 1'b0; stall_a = '0; in_data = 64'h44;
    tick();
    chk("b_adv44", db, 64'h44);
    stall_b = 6'b110000;
    for (int i = 0; i < 3; i++) tick();
    chk("b_pre_hcnt", 64'(hb), 64'd3);
    chk("b_pre_stuck", 64'(sb), 64'd0);
    stall_b = '0; in_data = 64'h55;
    tick();
    chk("b_adv55", db, 64'h55);
    stall_b = 6'b110000; in_data = 64'h66;
    tick();
    chk("b_h1_hcnt", 64'(hb), 64'd4);
    chk("b_h1_stuck", 64'(sb), 64'd0);
    tick();
    tick();
    chk("b_h3_hcnt", 64'(hb), 64'd6);
    chk("b_h3_stuck", 64'(sb), 64'd0);
    tick();
    chk("b_h4_hcnt", 64'(hb), 64'd7);
    chk("b_h4_stuck", 64'(sb), 64'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("b_sat_hcnt", 64'(hb), 64'd7);
    chk("b_sat_stuck", 64'(sb), 64'd1);
    chk("b_sat_data", db, 64'h55);
    clr_stats = 1'b1;
    tick();
    chk("clr_hcnt", 64'(hb), 64'd0);
    chk("clr_stuck", 64'(sb), 64'd0);
    chk("clr_bcnt", 64'(bb), 64'd0);
    chk("clr_valid", 64'(vb), 64'd1);
    chk("clr_data", db, 64'h55);
    clr_stats = 1'b0;
    tick();
    chk("post_clr_hcnt", 64'(hb), 64'd1);
    chk("post_clr_stuck", 64'(sb), 64'd0);
    stall_b = 6'b010000;
    for (int i = 0; i < 9; i++) tick();
    chk("b_bub_sat", 64'(bb), 64'd7);
    chk("b_bub_data_keep", db, 64'h55);
    chk("c_pre_bcnt", 64'(bc), 64'd0);
    stall_c = 6'b100000;
    tick();
    chk("top_valid", 64'(vc), 64'd0);
    chk("top_data", dc, 64'd0);
    chk("top_bcnt1", 64'(bc), 64'd1);
    chk("top_hcnt", 64'(hc), 64'd0);
    stall_c = 6'b110000;
    tick();
    chk("top_bcnt2", 64'(bc), 64'd2);
    chk("top_hcnt2", 64'(hc), 64'd0);
    stall_c = '0; in_data = 64'h77;
    tick();
    chk("top_adv", dc, 64'h77);
    stall_a = 6'b110000;
    tick();
    tick();
    chk("a_midhold_hcnt", 64'(ha), 64'd2);
    rst = 1'b1;
    tick();
    chk("midrst_valid", 64'(va), 64'd0);
    chk("midrst_data", da, 64'd0);
    chk("midrst_hcnt", 64'(ha), 64'd0);
    chk("midrst_bcnt", 64'(ba), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the general form of the per-stage latches between IF/ID/EX/MEM/WB. It carries an arbitrary-width payload plus a valid bit and is controlled by the global stall vector and a flush input. It adds the following to the fixed stage latches:
- bubble/hold classification derived from a configurable stage index
- optional payload clearing on bubbles
- saturating bubble/hold statistics counters
- a sticky stuck-stage detector for debug.

Parameters:
DATA_W, 64, payload width in bits (concatenation of all stage fields).
STALL_W, 6, width of the global stall vector.
STAGE, 4, stall bit index of the producing (upstream) stage; bit STAGE+1 is the consuming stage.
CLR_ON_BUBBLE, 1, 1: payload forced to RST_VAL on bubble/flush; 0: payload retained, only valid cleared.
RST_VAL, 0, payload value on reset, and on bubble/flush when CLR_ON_BUBBLE=1.
CNT_W, 16, width of the statistics counters.
STUCK_LIMIT, 1024, number of consecutive hold cycles that raises stuck (must be below 2^CNT_W).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  STALL_W  global stall vector, 1 = Stop, 0 = NoStop
flush  in  1  kill in-flight content (exception/branch), 1 = flush
in_valid  in  1  upstream payload valid
in_data  in  DATA_W  upstream payload
out_valid  out  1  registered valid to downstream
out_data  out  DATA_W  registered payload to downstream
bubble_cnt  out  CNT_W  saturating count of bubble-insert cycles
hold_cnt  out  CNT_W  saturating count of hold cycles
stuck  out  1  sticky: hold persisted STUCK_LIMIT consecutive cycles
clr_stats  in  1  synchronous clear of bubble_cnt, hold_cnt, stuck

Behaviour:
- Signal definitions:
  - up_stop = stall[STAGE].
  - dn_stop = stall[STAGE+1] if STAGE+1 < STALL_W, else constant 0.
  - STAGE >= STALL_W is illegal; it must be rejected at elaboration.
- Per-cycle action, evaluated at the rising edge in strict priority order:
  1. rst: out_valid=0, out_data=RST_VAL, bubble_cnt=0, hold_cnt=0, stuck=0, hold_age=0.
  2. flush: out_valid=0; out_data=RST_VAL if CLR_ON_BUBBLE, else unchanged; hold_age=0. Counters are not incremented. Flush overrides any stall.
  3. BUBBLE (up_stop=1, dn_stop=0): out_valid=0; out_data as for flush; bubble_cnt+1 (saturating); hold_age=0.
  4. ADVANCE (up_stop=0): out_valid=in_valid, out_data=in_data; hold_age=0. Advance takes effect even if dn_stop=1; upstream stall generation must prevent that combination.
  5. HOLD (up_stop=1, dn_stop=1): out_valid and out_data unchanged; hold_cnt+1 (saturating); hold_age+1 (saturating at STUCK_LIMIT).
- Latency: 1 cycle from in_* to out_*. There is no combinational path from any input to any output.
- Internal hold_age (width CNT_W):
  - When hold_age reaches STUCK_LIMIT during a HOLD, stuck is set on that edge.
  - stuck stays set until rst or clr_stats.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr_stats:
  - Zeroes bubble_cnt, hold_cnt, stuck and hold_age.
  - Has priority over a same-cycle increment, so the result is 0.
  - Does not affect out_valid or out_data.
- Reset mid-hold or mid-flush: reset wins and all state returns to reset values on that edge.
- Outputs are driven directly from flops.

Test Plan:
1. Reset then advance: rst=1 for 2 cycles, then stall=0, in_valid=1, in_data=0xA5 -> out_valid=0 and out_data=0 during reset; out_valid=1 and out_data=0xA5 one cycle after release.
2. Bubble (STAGE=4): stall=6'b010000 for 3 cycles with in_data=0x11 -> out_valid=0 and out_data=0 each cycle; bubble_cnt=3, hold_cnt=0. With CLR_ON_BUBBLE=0, out_data keeps the prior value 0xA5.
3. Hold: stall=6'b110000 for 5 cycles after 0x22 is latched -> out_data=0x22 and out_valid=1 throughout; hold_cnt=5; hold_age resets on the next advance.
4. Flush priority: flush=1 with stall=6'b110000 and out_valid=1 -> next cycle out_valid=0, out_data=0; hold_cnt unchanged.
5. Stuck and saturation: STUCK_LIMIT=4, CNT_W=3, continuous HOLD for 10 cycles -> stuck rises on the 4th hold edge; hold_cnt saturates at 7; clr_stats=1 coincident with a HOLD -> hold_cnt=0, stuck=0.
6. Top stage: STAGE=5, STALL_W=6, stall[5]=1 -> treated as BUBBLE (dn_stop=0); out_valid=0 and bubble_cnt increments.
